siso_frame_rx: RTL and testbench
================================

SISO_FRAME_RX -- requirements
Module: siso_frame_rx

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits; SHALL be a multiple of 4, minimum 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sync_in  input  1  frame-phase marker; nominal period is 4 cycles: 1,1,0,0.
REQ-005 din  input  1  serial data, MSB first, one bit per cycle.
REQ-006 out_ready  input  1  consumer accepts dout when high with dout_valid.
REQ-007 dout  output  WIDTH  last completed word.
REQ-008 dout_valid  output  1  dout holds an unconsumed word.
REQ-009 locked  output  1  receiver is aligned to sync_in.
REQ-010 sync_err  output  1  one-cycle pulse on loss of lock.
REQ-011 overrun  output  1  sticky dropped-word flag; present only with SISO_RX_OVERRUN_EN.

Function
REQ-012 FSM states: HUNT, VERIFY, LOCK; an internal 2-bit phase counter SHALL wrap 3->0. Expected sync_in is 1 at phases 0-1 and 0 at phases 2-3.
REQ-013 HUNT: a 0->1 transition on sync_in (previous-cycle sample 0, current 1) in cycle t SHALL set phase 0 for cycle t and enter VERIFY.
REQ-014 VERIFY: sync_in SHALL match the expected value in cycles t+1..t+4; any mismatch SHALL return to HUNT with no sync_err.
REQ-015 A match in cycle t+4 (phase 0) SHALL enter LOCK; locked SHALL be 1 from cycle t+5.
REQ-016 Data capture: din in cycle t+4 SHALL be bit WIDTH-1 of the first word. In LOCK, one bit per cycle SHALL be left-shifted into a WIDTH-bit register.
REQ-017 A word SHALL complete on every WIDTH-th captured bit; dout and dout_valid SHALL update in the following cycle. With WIDTH=8, the first word is valid in cycle t+12.
REQ-018 dout_valid SHALL stay high and dout SHALL stay stable until a cycle with out_ready=1, after which dout_valid clears.
REQ-019 If a word completes while dout_valid=1 and out_ready=1 in the same cycle, the new word SHALL load and dout_valid SHALL stay 1.
REQ-020 If a word completes while dout_valid=1 and out_ready=0, the new word SHALL be dropped and dout SHALL be unchanged.
REQ-021 In LOCK, a sync_in mismatch in any cycle SHALL move to HUNT, discard the partial word (including a word that would have completed that cycle), and clear locked. sync_err SHALL be 1 for exactly the next cycle.
REQ-022 An already-valid dout SHALL survive loss of lock.
REQ-023 HUNT after an error SHALL evaluate edges only from the cycle after the mismatch.
REQ-024 out_ready SHALL be ignored when dout_valid=0.

Reset
REQ-025 rst=1 SHALL immediately force: state HUNT, phase 0, shift register and bit counter 0, dout 0, dout_valid 0, locked 0, sync_err 0, overrun 0, previous-sync sample 0.
REQ-026 Reset mid-word SHALL discard the partial word. After release, the block SHALL require a full HUNT/VERIFY sequence before capturing data.

Configuration
REQ-027 Macro SISO_RX_OVERRUN_EN defined: the overrun port exists; it SHALL set on any REQ-020 drop and clear only on rst.
REQ-028 Macro SISO_RX_OVERRUN_EN undefined: the overrun port and its logic are absent; drops are silent, with all other behaviour identical.

Verification
REQ-029 Reset, then sync 1100 repeating with first rise at cycle t, din=10100101 from t+4, out_ready=1 -> locked=1 at t+5; dout=0xA5 and dout_valid=1 in t+12 only.
REQ-030 out_ready=0, words 0x3C then 0xC3 -> dout holds 0x3C and 0xC3 is dropped; overrun=1 with macro; after out_ready=1 for one cycle, dout_valid=0.
REQ-031 dout_valid=1 and out_ready=1 in the same cycle that word 0x5A completes -> next cycle dout=0x5A and dout_valid=1.
REQ-032 sync_in forced 1 at a phase-2 cycle mid-word -> sync_err=1 for one cycle, locked=0, partial word never appears; clean sync relocks 5 cycles after the next rise.
REQ-033 rst pulsed at bit 5 of a word -> all outputs 0 immediately; no word is emitted until relock plus 8 bits.

Source files
------------

// File: rtl/siso_frame_rx.sv
// siso_frame_rx: serial frame receiver aligned to a 1,1,0,0 sync_in pattern.
// The receiver hunts for a rising edge on sync_in and checks one full period
// before it locks. While locked it shifts din in MSB first and presents each
// completed WIDTH-bit word on dout with a valid/ready handshake.
// Optional feature macro: SISO_RX_OVERRUN_EN adds the sticky 'overrun' output.
// Handshake: a word on dout is consumed on a rising clk edge where
// dout_valid=1 and out_ready=1; out_ready has no effect while dout_valid=0.
// fsm_state is a debug view of the FSM: 0=HUNT, 1=VERIFY, 2=LOCK.
`timescale 1ns/1ps

module siso_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic             din,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [1:0]       fsm_state
`ifdef SISO_RX_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       phase, phase_n;
  logic             prev_sync;
  // Holds the WIDTH-1 most recent bits; the word is completed by the
  // current din bit, so the top bit never needs a register of its own.
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0]    bitcnt;

  logic exp_sync;
  logic match;
  logic capture;
  logic clear;
  logic lose;
  logic word_done;
  logic load;

  assign locked    = (state == LOCK);
  assign fsm_state = state;

  // Next-state, phase tracking and capture/discard decisions.
  always_comb begin
    exp_sync = ~phase[1];
    match    = (sync_in == exp_sync);
    state_n  = state;
    phase_n  = phase + 2'd1;
    capture  = 1'b0;
    clear    = 1'b0;
    lose     = 1'b0;
    case (state)
      HUNT: begin
        // Phase stays at 0 while hunting, so the edge cycle is phase 0.
        clear   = 1'b1;
        phase_n = 2'd0;
        if (!prev_sync && sync_in) begin
          state_n = VERIFY;
          phase_n = 2'd1;
        end
      end
      VERIFY: begin
        if (!match) begin
          state_n = HUNT;
          phase_n = 2'd0;
          clear   = 1'b1;
        end else if (phase == 2'd0) begin
          // Full period confirmed; this cycle's din is the first word's MSB.
          state_n = LOCK;
          capture = 1'b1;
        end
      end
      LOCK: begin
        if (!match) begin
          state_n = HUNT;
          phase_n = 2'd0;
          clear   = 1'b1;
          lose    = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      default: begin
        state_n = HUNT;
        phase_n = 2'd0;
        clear   = 1'b1;
      end
    endcase
    word_done = capture && (bitcnt == CW'(WIDTH - 1));
    load      = word_done && (!dout_valid || out_ready);
  end

  // FSM state, phase counter and previous sync sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      phase     <= 2'd0;
      prev_sync <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      prev_sync <= sync_in;
    end
  end

  // Shift register and bit counter; any loss of alignment drops the partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (clear) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (capture) begin
      shreg  <= {shreg[WIDTH-3:0], din};
      bitcnt <= word_done ? '0 : bitcnt + 1'b1;
    end
  end

  // Output word register: load when empty or being consumed, else keep the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      sync_err <= lose;
      if (load) begin
        dout       <= {shreg, din};
        dout_valid <= 1'b1;
      end else if (dout_valid && out_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef SISO_RX_OVERRUN_EN
  logic drop;
  assign drop = word_done && dout_valid && !out_ready;

  // Sticky flag for a completed word lost because dout was still occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_siso_frame_rx.sv
// Testbench for siso_frame_rx (WIDTH=8): table of back-to-back words under
// different out_ready patterns, plus hand-written loss-of-lock and
// mid-word reset sequences. Consumed words are compared against a queue.
`timescale 1ns/1ps

module tb_siso_frame_rx;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sync_in = 1'b0;
  logic         din = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         locked;
  logic         sync_err;
  logic [1:0]   fsm_state;
`ifdef SISO_RX_OVERRUN_EN
  logic         overrun;
`endif

  always #5 clk = ~clk;

  siso_frame_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .din        (din),
    .out_ready  (out_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err),
    .fsm_state  (fsm_state)
`ifdef SISO_RX_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_err = 0;
  int           tp = 2;
  logic [W-1:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Every handshake on the DUT output pops one expected word.
  always @(negedge clk) begin
    if (!rst && dout_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got 0x%0h expected no word at %0t", dout, $time);
      end else begin
        check("sb_word", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick_raw(input logic s, input logic d, input logic r);
    sync_in   = s;
    din       = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // One cycle with the nominal 1,1,0,0 sync pattern.
  task automatic tick_sync(input logic d, input logic r);
    tick_raw(((tp % 4) < 2) ? 1'b1 : 1'b0, d, r);
    tp++;
  endtask

  // Advance to the next phase-0 rise and walk one verify period.
  task automatic relock();
    while ((tp % 4) != 0) tick_sync(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick_sync(1'b0, 1'b1);
    check("locked_t4", 32'(locked), 32'd0);
    check("valid_before_word", 32'(dout_valid), 32'd0);
  endtask

  // mode 0: ready low, 1: ready high, 2: ready only on the completing bit.
  task automatic send_word(input logic [W-1:0] w, input int mode, output logic fv);
    logic r;
    fv = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      r = (mode == 1) ? 1'b1 : ((mode == 2) ? (i == 0) : 1'b0);
      tick_sync(w[i], r);
      check("locked_in_word", 32'(locked), 32'd1);
      if (i == W - 1) fv = dout_valid;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0] word;
    int           mode;
    logic [W-1:0] exp_dout;
    logic         exp_fv;
    logic         kept;
    logic         exp_ovr;
  } row_t;

  row_t rows[7];

  initial begin
    logic fv;

    rows[0] = '{word: 8'hA5, mode: 1, exp_dout: 8'hA5, exp_fv: 1'b0, kept: 1'b1, exp_ovr: 1'b0};
    rows[1] = '{word: 8'h0F, mode: 1, exp_dout: 8'h0F, exp_fv: 1'b0, kept: 1'b1, exp_ovr: 1'b0};
    rows[2] = '{word: 8'h3C, mode: 1, exp_dout: 8'h3C, exp_fv: 1'b0, kept: 1'b1, exp_ovr: 1'b0};
    rows[3] = '{word: 8'hC3, mode: 0, exp_dout: 8'h3C, exp_fv: 1'b1, kept: 1'b0, exp_ovr: 1'b1};
    rows[4] = '{word: 8'h5A, mode: 2, exp_dout: 8'h5A, exp_fv: 1'b1, kept: 1'b1, exp_ovr: 1'b1};
    rows[5] = '{word: 8'h96, mode: 0, exp_dout: 8'h5A, exp_fv: 1'b1, kept: 1'b0, exp_ovr: 1'b1};
    rows[6] = '{word: 8'h81, mode: 1, exp_dout: 8'h81, exp_fv: 1'b0, kept: 1'b1, exp_ovr: 1'b1};

    // Reset state.
    for (int i = 0; i < 3; i++) tick_raw($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
`ifdef SISO_RX_OVERRUN_EN
    check("rst_overrun", 32'(overrun), 32'd0);
`endif
    rst = 1'b0;

    // Lock up and stream the table words back to back.
    tp = 2;
    relock();
    foreach (rows[k]) begin
      if (rows[k].kept) exp_q.push_back(rows[k].word);
      send_word(rows[k].word, rows[k].mode, fv);
      check("row_first_valid", 32'(fv), 32'(rows[k].exp_fv));
      check("row_dout", 32'(dout), 32'(rows[k].exp_dout));
      check("row_valid", 32'(dout_valid), 32'd1);
`ifdef SISO_RX_OVERRUN_EN
      check("row_overrun", 32'(overrun), 32'(rows[k].exp_ovr));
`endif
    end

    // Loss of lock mid-word with 0x81 still unconsumed.
    for (int i = 0; i < 3; i++) tick_sync($urandom_range(0, 1), 1'b0);
    while ((tp % 4) != 2) tick_sync($urandom_range(0, 1), 1'b0);
    tick_raw(1'b1, 1'b0, 1'b0);
    tp++;
    check("loss_sync_err", 32'(sync_err), 32'd1);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_state", 32'(fsm_state), 32'd0);
    check("loss_dout_kept", 32'(dout), 32'h81);
    check("loss_valid_kept", 32'(dout_valid), 32'd1);
    tick_sync(1'b0, 1'b1);
    check("loss_err_pulse_end", 32'(sync_err), 32'd0);
    check("consume_clears_valid", 32'(dout_valid), 32'd0);
    relock();
    send_word(8'h69, 1, fv);
    check("relock_first_valid", 32'(fv), 32'd0);
    check("relock_dout", 32'(dout), 32'h69);
    check("relock_valid", 32'(dout_valid), 32'd1);

    // Reset at bit 5 of a word, with 0x69 still held.
    for (int i = 0; i < 5; i++) tick_sync(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_sync_err", 32'(sync_err), 32'd0);
    check("midrst_state", 32'(fsm_state), 32'd0);
`ifdef SISO_RX_OVERRUN_EN
    check("midrst_overrun", 32'(overrun), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    tp = 2;
    relock();
    exp_q.push_back(8'hE7);
    send_word(8'hE7, 1, fv);
    check("postrst_first_valid", 32'(fv), 32'd0);
    check("postrst_dout", 32'(dout), 32'hE7);
    check("postrst_valid", 32'(dout_valid), 32'd1);
    tick_sync(1'b0, 1'b1);
    check("final_valid", 32'(dout_valid), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
